// File: rtl/game_wallet_pkg.sv
// Shared types for the game wallet: FSM states and the latched winner index.
package game_wallet_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    COMMIT  = 2'd2,
    RELEASE = 2'd3
  } wallet_state_e;

  // Winner index wide enough for up to 7 shop channels plus the upgrade slot
  localparam int unsigned IDX_W = 3;
  typedef logic [IDX_W-1:0] win_idx_t;
  localparam win_idx_t UPGRADE_IDX = win_idx_t'(2**IDX_W - 1);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_wallet_arbiter.sv
// Fixed-priority purchase arbiter: upgrade first, then lowest-numbered shop channel.
module wallet_arbiter
  import game_wallet_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic            upgrade_req,
  output logic            valid_c,
  output logic [N_CH:0]   grant_c,
  output win_idx_t        idx_c
);

  always_comb begin
    valid_c = upgrade_req | (|req);
    grant_c = '0;
    idx_c   = UPGRADE_IDX;
    if (upgrade_req) begin
      grant_c[N_CH] = 1'b1;
    end else begin
      // Scan high to low so the lowest active index wins
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant_c    = '0;
          grant_c[i] = 1'b1;
          idx_c      = win_idx_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/game_wallet.sv
// Multi-channel currency wallet: level-scaled income, arbitrated purchases and upgrades.
// Define GAME_WALLET_TICK_SYNC_EN when gameTick is an asynchronous slow clock.
module game_wallet
  import game_wallet_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned BAL_W     = 11,
  parameter int unsigned COST_W    = 12,
  parameter int unsigned LVL_W     = 2,
  parameter int unsigned MAX_BAL   = 2000,
  parameter int unsigned START_BAL = 50,
  parameter int unsigned BASE_INC  = 10,
  parameter int unsigned UPG_BASE  = 100
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   gameTick,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*COST_W-1:0] cost,
  input  logic                   upgradeReq,
  output logic [N_CH-1:0]        ack,
  output logic                   upgAck,
  output logic                   buySucc,
  output logic [BAL_W-1:0]       balance,
  output logic [LVL_W-1:0]       level,
  output logic                   maxed,
  output logic                   lvlMaxed
);

  localparam int unsigned CMP_W = max_u(COST_W, BAL_W) + 1;
  localparam int unsigned SUM_W = CMP_W + 1;

  wallet_state_e    state_q, state_d;
  win_idx_t         win_idx_q, win_idx_d;
  logic [CMP_W-1:0] cost_q, cost_d;
  logic             ok_q, ok_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [N_CH-1:0]  ack_q, ack_d;
  logic             upg_ack_q, upg_ack_d;
  logic             succ_q, succ_d;

  logic             credit_c;
  logic             arb_valid_c;
  logic [N_CH:0]    arb_grant_c;
  win_idx_t         arb_idx_c;
  logic [CMP_W-1:0] sel_cost_c;
  logic [CMP_W-1:0] upg_cost_c;
  logic [SUM_W-1:0] income_c;
  logic [SUM_W-1:0] debit_c;
  logic [SUM_W-1:0] sum_c;
  logic             win_req_c;
  logic             win_is_upg_c;
  logic             lvl_maxed_c;

`ifdef GAME_WALLET_TICK_SYNC_EN
  // Two-flop synchronizer plus one history flop for rising-edge detection
  logic [2:0] tick_sync_q, tick_sync_d;

  always_comb begin
    tick_sync_d = {tick_sync_q[1:0], gameTick};
    credit_c    = tick_sync_q[1] & ~tick_sync_q[2];
  end

  always_ff @(posedge Clk) begin
    if (Reset) tick_sync_q <= '0;
    else       tick_sync_q <= tick_sync_d;
  end
`else
  assign credit_c = gameTick;
`endif

  wallet_arbiter #(.N_CH(N_CH)) u_arbiter (
    .req         (req),
    .upgrade_req (upgradeReq),
    .valid_c     (arb_valid_c),
    .grant_c     (arb_grant_c),
    .idx_c       (arb_idx_c)
  );

  assign lvl_maxed_c  = (level_q == {LVL_W{1'b1}});
  assign win_is_upg_c = (win_idx_q == UPGRADE_IDX);

  // Pricing and income both scale with the current level
  always_comb begin
    upg_cost_c = CMP_W'(UPG_BASE) << level_q;
    income_c   = SUM_W'(BASE_INC) * (SUM_W'(level_q) + SUM_W'(1));
  end

  always_comb begin
    sel_cost_c = '0;
    if (arb_grant_c[N_CH]) sel_cost_c = upg_cost_c;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_grant_c[i]) sel_cost_c = CMP_W'(cost[i*COST_W +: COST_W]);
    end
  end

  // Level of the latched winner's request, used to close the 4-phase handshake
  always_comb begin
    win_req_c = win_is_upg_c ? upgradeReq : 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (win_idx_q == win_idx_t'(i)) win_req_c = req[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_valid_c) state_d = CHECK;
      CHECK:   state_d = COMMIT;
      COMMIT:  state_d = RELEASE;
      RELEASE: if (!win_req_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win_idx_d = win_idx_q;
    cost_d    = cost_q;
    ok_d      = ok_q;
    level_d   = level_q;
    ack_d     = '0;
    upg_ack_d = 1'b0;
    succ_d    = 1'b0;
    debit_c   = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          win_idx_d = arb_idx_c;
          cost_d    = sel_cost_c;
        end
      end
      CHECK: begin
        ok_d = (cost_q <= CMP_W'(balance_q)) && !(win_is_upg_c && lvl_maxed_c);
      end
      COMMIT: begin
        succ_d = ok_q;
        if (win_is_upg_c) upg_ack_d = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
          if (win_idx_q == win_idx_t'(i)) ack_d[i] = 1'b1;
        end
        if (ok_q) begin
          debit_c = SUM_W'(cost_q);
          if (win_is_upg_c) level_d = level_q + LVL_W'(1);
        end
      end
      default: ;
    endcase

    // Debit never exceeds balance, so the sum stays non-negative before clamping
    sum_c     = SUM_W'(balance_q) - debit_c + (credit_c ? income_c : '0);
    balance_d = (sum_c > SUM_W'(MAX_BAL)) ? BAL_W'(MAX_BAL) : BAL_W'(sum_c);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      win_idx_q <= UPGRADE_IDX;
      cost_q    <= '0;
      ok_q      <= 1'b0;
      balance_q <= BAL_W'(START_BAL);
      level_q   <= '0;
      ack_q     <= '0;
      upg_ack_q <= 1'b0;
      succ_q    <= 1'b0;
    end else begin
      win_idx_q <= win_idx_d;
      cost_q    <= cost_d;
      ok_q      <= ok_d;
      balance_q <= balance_d;
      level_q   <= level_d;
      ack_q     <= ack_d;
      upg_ack_q <= upg_ack_d;
      succ_q    <= succ_d;
    end
  end

  assign ack      = ack_q;
  assign upgAck   = upg_ack_q;
  assign buySucc  = succ_q;
  assign balance  = balance_q;
  assign level    = level_q;
  assign maxed    = (balance_q == BAL_W'(MAX_BAL));
  assign lvlMaxed = lvl_maxed_c;

endmodule

// File: tb/tb_game_wallet.sv
// Directed bench for game_wallet (default build: Clk-synchronous gameTick).
module tb_game_wallet;

  localparam int N_CH   = 4;
  localparam int COST_W = 12;

  logic                   Clk;
  logic                   Reset;
  logic                   gameTick;
  logic [N_CH-1:0]        req;
  logic [N_CH*COST_W-1:0] cost;
  logic                   upgradeReq;
  logic [N_CH-1:0]        ack;
  logic                   upgAck;
  logic                   buySucc;
  logic [10:0]            balance;
  logic [1:0]             level;
  logic                   maxed;
  logic                   lvlMaxed;

  int total;
  int passed;

  game_wallet dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .gameTick   (gameTick),
    .req        (req),
    .cost       (cost),
    .upgradeReq (upgradeReq),
    .ack        (ack),
    .upgAck     (upgAck),
    .buySucc    (buySucc),
    .balance    (balance),
    .level      (level),
    .maxed      (maxed),
    .lvlMaxed   (lvlMaxed)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    gameTick = 1'b1;
    repeat (n) step();
    gameTick = 1'b0;
  endtask

  // ch == N_CH selects the upgrade channel
  task automatic run_buy(input string tag, input int ch, input logic [11:0] c,
                         input logic exp_succ, input int exp_bal);
    logic [N_CH-1:0] exp_ack;
    exp_ack = '0;
    if (ch == N_CH) upgradeReq = 1'b1;
    else begin
      cost[ch*COST_W +: COST_W] = c;
      req[ch] = 1'b1;
      exp_ack[ch] = 1'b1;
    end
    step();
    check({tag, "_noack0"}, 32'(ack), 32'd0);
    step();
    check({tag, "_noack1"}, 32'(ack | N_CH'(upgAck)), 32'd0);
    step();
    check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "_upgack"}, 32'(upgAck), 32'(ch == N_CH));
    check({tag, "_succ"}, 32'(buySucc), 32'(exp_succ));
    check({tag, "_bal"}, 32'(balance), 32'(exp_bal));
    if (ch == N_CH) upgradeReq = 1'b0;
    else req[ch] = 1'b0;
    step();
    check({tag, "_ackdrop"}, 32'(ack | N_CH'(upgAck)), 32'd0);
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    Reset      = 1'b1;
    gameTick   = 1'b0;
    req        = '0;
    cost       = '0;
    upgradeReq = 1'b0;
    step();
    step();
    Reset = 1'b0;

    check("rst_bal", 32'(balance), 32'd50);
    check("rst_lvl", 32'(level), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_upgack", 32'(upgAck), 32'd0);
    check("rst_succ", 32'(buySucc), 32'd0);
    check("rst_maxed", 32'(maxed), 32'd0);
    check("rst_lvlmaxed", 32'(lvlMaxed), 32'd0);

    // 1: five synchronous ticks at level 0
    gameTick = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1_bal", 32'(balance), 32'(50 + 10 * k));
      check("t1_ack", 32'(ack), 32'd0);
    end
    gameTick = 1'b0;

    // 2: affordable purchase; 3: one unit short
    run_buy("t2", 2, 12'd80, 1'b1, 20);
    run_buy("t3", 1, 12'd21, 1'b0, 20);

    // 4: simultaneous requests, lowest index first, next waits for release
    cost[0*COST_W +: COST_W] = 12'd5;
    cost[3*COST_W +: COST_W] = 12'd10;
    req[0] = 1'b1;
    req[3] = 1'b1;
    step();
    step();
    step();
    check("t4_ack0", 32'(ack), 32'h1);
    check("t4_bal0", 32'(balance), 32'd15);
    step();
    check("t4_hold0", 32'(ack), 32'd0);
    step();
    check("t4_hold1", 32'(ack), 32'd0);
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_wait3", 32'(ack), 32'd0);
    end
    step();
    check("t4_ack3", 32'(ack), 32'h8);
    check("t4_succ3", 32'(buySucc), 32'd1);
    check("t4_bal3", 32'(balance), 32'd5);
    req[3] = 1'b0;
    step();

    // 5: tick lands on the commit edge, result saturates
    ticks(199);
    check("t5_pre", 32'(balance), 32'd1995);
    cost[2*COST_W +: COST_W] = 12'd5;
    req[2] = 1'b1;
    step();
    step();
    gameTick = 1'b1;
    step();
    gameTick = 1'b0;
    check("t5_ack", 32'(ack), 32'h4);
    check("t5_succ", 32'(buySucc), 32'd1);
    check("t5_bal", 32'(balance), 32'd2000);
    check("t5_maxed", 32'(maxed), 32'd1);
    req[2] = 1'b0;
    step();
    ticks(1);
    check("t5_sat", 32'(balance), 32'd2000);

    // 6: upgrades with doubling cost and scaled income
    run_buy("t6_spend", 0, 12'd1500, 1'b1, 500);
    check("t6_unmaxed", 32'(maxed), 32'd0);
    run_buy("t6_up0", N_CH, 12'd0, 1'b1, 400);
    check("t6_lvl1", 32'(level), 32'd1);
    ticks(1);
    check("t6_inc20", 32'(balance), 32'd420);
    run_buy("t6_up1", N_CH, 12'd0, 1'b1, 220);
    check("t6_lvl2", 32'(level), 32'd2);
    ticks(6);
    check("t6_inc30", 32'(balance), 32'd400);
    run_buy("t6_up2", N_CH, 12'd0, 1'b1, 0);
    check("t6_lvl3", 32'(level), 32'd3);
    check("t6_lvlmaxed", 32'(lvlMaxed), 32'd1);
    ticks(20);
    check("t6_inc40", 32'(balance), 32'd800);
    run_buy("t6_up3", N_CH, 12'd0, 1'b0, 800);
    check("t6_lvlstay", 32'(level), 32'd3);
    run_buy("t6_zero", 1, 12'd0, 1'b1, 800);
    run_buy("t6_huge", 3, 12'd4095, 1'b0, 800);

    // 7: reset while a purchase sits in CHECK
    cost[0*COST_W +: COST_W] = 12'd10;
    req[0] = 1'b1;
    step();
    Reset = 1'b1;
    req[0] = 1'b0;
    step();
    Reset = 1'b0;
    check("t7_ack", 32'(ack), 32'd0);
    check("t7_bal", 32'(balance), 32'd50);
    check("t7_lvl", 32'(level), 32'd0);
    check("t7_lvlmaxed", 32'(lvlMaxed), 32'd0);
    step();
    check("t7_idle", 32'(ack), 32'd0);
    run_buy("t7_buy", 1, 12'd50, 1'b1, 0);
    ticks(1);
    check("t7_inc", 32'(balance), 32'd10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
